// File: rtl/hram_io_responder.sv
// hram_io_responder
//
// Bus target on the CPU external memory bus. Serves the 127-byte high RAM,
// the interrupt flag register (IF) and the interrupt enable register (IE),
// latches peripheral interrupt requests and raises irq_pending for the CPU.
// Its data_out is muxed onto the CPU read path whenever hit=1.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst          asynchronous reset, active-low
//   addr_bus     CPU address bus (16)
//   data_in      CPU write data (8)
//   rd, wr       level read/write strobes, held for the whole access
//   int_req      peripheral interrupt set pulses (VBlank, STAT, Timer, Serial, Joypad)
//   int_ack      CPU interrupt acknowledge, clears the matching IF bit
//   data_out     registered read data, 8'hFF after reset and on missed reads
//   hit          combinational: addr_bus decodes to HRAM, IF or IE
//   irq_pending  registered |(IE[4:0] & IF[4:0]), one cycle behind the registers
//   ready        responder initialised
//
// Build option
//   HRAM_CLEAR_EN  when defined, HRAM is swept to zero after reset release
//                  (one byte per cycle); ready is low during the sweep, HRAM
//                  reads return 8'hFF and HRAM writes are dropped meanwhile.
//                  When undefined, ready is tied high and HRAM powers up
//                  with undefined contents.

module hram_io_responder #(
  parameter logic [15:0] HRAM_BASE  = 16'hFF80,
  parameter int          HRAM_DEPTH = 127,
  parameter logic [15:0] IF_ADDR    = 16'hFF0F,
  parameter logic [15:0] IE_ADDR    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr_bus,
  input  logic [7:0]  data_in,
  input  logic        rd,
  input  logic        wr,
  input  logic [4:0]  int_req,
  input  logic [4:0]  int_ack,
  output logic [7:0]  data_out,
  output logic        hit,
  output logic        irq_pending,
  output logic        ready
);

  localparam logic [15:0] HRAM_LAST = HRAM_BASE + 16'(HRAM_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_HOLD
  } state_t;

  state_t      state, state_n;
  logic        rd_fire, wr_fire, miss_rd;
  logic        hram_hit, if_hit, ie_hit;
  logic [6:0]  hram_idx;
  logic [7:0]  rd_val;
  logic [4:0]  if_q, if_next;
  logic [7:0]  ie_q;
  logic        sweep_busy;
  logic        base_we;
  logic        mem_we;
  logic [6:0]  mem_idx;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem [0:HRAM_DEPTH-1];

  // Address decode: exact compares, HRAM index is the low 7 bits of the offset
  assign hram_hit = (addr_bus >= HRAM_BASE) && (addr_bus <= HRAM_LAST);
  assign if_hit   = (addr_bus == IF_ADDR);
  assign ie_hit   = (addr_bus == IE_ADDR);
  assign hit      = hram_hit || if_hit || ie_hit;
  assign hram_idx = addr_bus[6:0] - HRAM_BASE[6:0];

  // Access FSM: actions fire only on the edge that leaves IDLE, so a strobe
  // held for many cycles produces exactly one load or write.
  always_comb begin
    state_n = state;
    rd_fire = 1'b0;
    wr_fire = 1'b0;
    miss_rd = 1'b0;
    case (state)
      S_IDLE: begin
        if (rd && !wr && hit) begin
          state_n = S_READ;
          rd_fire = 1'b1;
        end else if (wr && !rd && hit) begin
          state_n = S_WRITE;
          wr_fire = 1'b1;
        end else if (rd && !wr) begin
          miss_rd = 1'b1;
        end
      end
      S_READ:  state_n = S_HOLD;
      S_WRITE: state_n = S_HOLD;
      S_HOLD:  if (!rd && !wr) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Read mux: unused IF bits read as ones
  always_comb begin
    rd_val = 8'hFF;
    if (hram_hit)    rd_val = sweep_busy ? 8'hFF : mem[hram_idx];
    else if (if_hit) rd_val = {3'b111, if_q};
    else if (ie_hit) rd_val = ie_q;
  end

  // IF update order: CPU write, then acknowledge clear, then request set,
  // so a request always wins on the bit it touches.
  always_comb begin
    if_next = if_q;
    if (wr_fire && if_hit) if_next = data_in[4:0];
    if_next = (if_next & ~int_ack) | int_req;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out    <= 8'hFF;
      if_q        <= 5'h00;
      ie_q        <= 8'h00;
      irq_pending <= 1'b0;
    end else begin
      if (rd_fire)      data_out <= rd_val;
      else if (miss_rd) data_out <= 8'hFF;
      if (wr_fire && ie_hit) ie_q <= data_in;
      if_q        <= if_next;
      irq_pending <= |(ie_q[4:0] & if_q);
    end
  end

  // The RAM array has no reset; a write presented while rst is low is
  // blocked so a strobe in flight at reset never lands.
  assign base_we = wr_fire && hram_hit && !sweep_busy && rst;

`ifdef HRAM_CLEAR_EN
  logic       clr_busy;
  logic [6:0] clr_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_busy <= 1'b1;
      clr_idx  <= 7'd0;
    end else if (clr_busy) begin
      clr_idx <= clr_idx + 7'd1;
      if (clr_idx == 7'(HRAM_DEPTH - 1)) clr_busy <= 1'b0;
    end
  end

  assign sweep_busy = clr_busy;
  assign ready      = !clr_busy;

  always_comb begin
    mem_we    = base_we;
    mem_idx   = hram_idx;
    mem_wdata = data_in;
    if (clr_busy) begin
      mem_we    = 1'b1;
      mem_idx   = clr_idx;
      mem_wdata = 8'h00;
    end
  end
`else
  assign sweep_busy = 1'b0;
  assign ready      = 1'b1;
  assign mem_we     = base_we;
  assign mem_idx    = hram_idx;
  assign mem_wdata  = data_in;
`endif

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wdata;
  end

endmodule

// File: tb/tb_hram_io_responder.sv
// Self-checking bench for hram_io_responder: directed bus scenarios followed
// by randomized accesses and interrupt traffic, compared against a
// transaction-level model of the register/RAM contents.

module tb_hram_io_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr_bus;
  logic [7:0]  data_in;
  logic        rd, wr;
  logic [4:0]  int_req, int_ack;
  logic [7:0]  data_out;
  logic        hit, irq_pending, ready;

  always #5 clk = ~clk;

  hram_io_responder dut (
    .clk         (clk),
    .rst         (rst),
    .addr_bus    (addr_bus),
    .data_in     (data_in),
    .rd          (rd),
    .wr          (wr),
    .int_req     (int_req),
    .int_ack     (int_ack),
    .data_out    (data_out),
    .hit         (hit),
    .irq_pending (irq_pending),
    .ready       (ready)
  );

`ifdef HRAM_CLEAR_EN
  localparam int SWEEP = 127;
`else
  localparam int SWEEP = 0;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  bit rnd_irq = 1'b0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model: architectural contents only
  logic [7:0] m_hram [127];
  logic [4:0] m_if;
  logic [7:0] m_ie;
  logic       m_pend;
  logic [7:0] m_dout;
  int         m_clear;

  function automatic bit is_hram(input logic [15:0] a);
    return (a >= 16'hFF80) && (a <= 16'hFFFE);
  endfunction

  function automatic bit m_hit(input logic [15:0] a);
    return is_hram(a) || (a == 16'hFF0F) || (a == 16'hFFFF);
  endfunction

  function automatic logic [7:0] m_read(input logic [15:0] a);
    if (is_hram(a))     return (m_clear > 0) ? 8'hFF : m_hram[int'(a - 16'hFF80)];
    if (a == 16'hFF0F)  return {3'b111, m_if};
    if (a == 16'hFFFF)  return m_ie;
    return 8'hFF;
  endfunction

  task automatic model_reset();
    m_if    = 5'h00;
    m_ie    = 8'h00;
    m_pend  = 1'b0;
    m_dout  = 8'hFF;
    m_clear = SWEEP;
  endtask

  // One clock cycle; 'action' marks the first edge of an access.
  task automatic tick(input bit action);
    logic [4:0] nif;
    logic       npend;
    #1;
    if (rd || wr) chk("hit", hit, m_hit(addr_bus));
    @(posedge clk);
    npend = |(m_ie[4:0] & m_if);
    nif   = m_if;
    if (action) begin
      if (rd && !wr) m_dout = m_hit(addr_bus) ? m_read(addr_bus) : 8'hFF;
      if (wr && !rd && m_hit(addr_bus)) begin
        if (is_hram(addr_bus) && m_clear == 0) m_hram[int'(addr_bus - 16'hFF80)] = data_in;
        if (addr_bus == 16'hFF0F) nif = data_in[4:0];
        if (addr_bus == 16'hFFFF) m_ie = data_in;
      end
    end
    m_if   = (nif & ~int_ack) | int_req;
    m_pend = npend;
    if (m_clear > 0) begin
      m_clear--;
      if (m_clear == 0) for (int i = 0; i < 127; i++) m_hram[i] = 8'h00;
    end
    @(negedge clk);
    chk("data_out", data_out, m_dout);
    chk("irq_pending", irq_pending, m_pend);
    chk("ready", ready, m_clear == 0);
    int_req = 5'd0;
    int_ack = 5'd0;
    if (rnd_irq) begin
      if ($urandom_range(3) == 0) int_req = 5'($urandom);
      if ($urandom_range(3) == 0) int_ack = 5'($urandom);
    end
  endtask

  task automatic start(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
    rd = r; wr = w; addr_bus = a; data_in = d;
  endtask

  task automatic finish_acc();
    rd = 1'b0; wr = 1'b0;
    tick(0);
    tick(0);
  endtask

  task automatic access(input logic r, input logic w, input logic [15:0] a,
                        input logic [7:0] d, input int hold);
    start(r, w, a, d);
    tick(1);
    for (int i = 1; i < hold; i++) begin
      data_in = 8'($urandom);
      tick(0);
    end
    finish_acc();
  endtask

  task automatic read_lit(input string tag, input logic [15:0] a, input logic [7:0] exp);
    start(1'b1, 1'b0, a, 8'h00);
    tick(1);
    chk(tag, data_out, exp);
    finish_acc();
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_data_out", data_out, 8'hFF);
    chk("rst_irq", irq_pending, 1'b0);
    chk("rst_ready", ready, SWEEP == 0);
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; rd = 1'b0; wr = 1'b0; addr_bus = 16'h0000; data_in = 8'h00;
    int_req = 5'd0; int_ack = 5'd0;
    for (int i = 0; i < 127; i++) m_hram[i] = 8'h00;
    @(negedge clk);
    apply_reset();
`ifdef HRAM_CLEAR_EN
    read_lit("sweep_rd_ff", 16'hFF85, 8'hFF);
    access(1'b0, 1'b1, 16'hFF86, 8'h77, 1);
`endif
    while (m_clear > 0) tick(0);
    read_lit("rst_if", 16'hFF0F, 8'hE0);
    read_lit("rst_ie", 16'hFFFF, 8'h00);

    // Give every HRAM byte a known value
    for (int i = 0; i < 127; i++) access(1'b0, 1'b1, 16'hFF80 + 16'(i), 8'($urandom), 1);

    // Write then read back with single-cycle latency
    access(1'b0, 1'b1, 16'hFF80, 8'h5A, 1);
    start(1'b1, 1'b0, 16'hFF80, 8'h00);
    tick(1);
    chk("t1_read", data_out, 8'h5A);
    chk("t1_hit", hit, 1'b1);
    finish_acc();

    // Held write captures only the entry-edge data
    start(1'b0, 1'b1, 16'hFFFE, 8'h11);
    tick(1);
    data_in = 8'h22;
    tick(0);
    tick(0);
    finish_acc();
    read_lit("t2_held_wr", 16'hFFFE, 8'h11);

    // Interrupt set, pending, acknowledge
    access(1'b0, 1'b1, 16'hFFFF, 8'h04, 1);
    int_req = 5'b00100;
    tick(0);
    tick(0);
    chk("t3_pend_set", irq_pending, 1'b1);
    read_lit("t3_if_set", 16'hFF0F, 8'hE4);
    int_ack = 5'b00100;
    tick(0);
    tick(0);
    chk("t3_pend_clr", irq_pending, 1'b0);
    read_lit("t3_if_clr", 16'hFF0F, 8'hE0);

    // Request wins over a coincident CPU write
    start(1'b0, 1'b1, 16'hFF0F, 8'h00);
    int_req = 5'b00001;
    tick(1);
    finish_acc();
    read_lit("t4_if_race", 16'hFF0F, 8'hE1);

    // Misses and rd+wr collisions leave the FSM in IDLE
    start(1'b1, 1'b0, 16'hFF7F, 8'h00);
    tick(1);
    chk("t5_miss_hit", hit, 1'b0);
    chk("t5_miss_dout", data_out, 8'hFF);
    start(1'b0, 1'b1, 16'hFF81, 8'h3C);
    tick(1);
    finish_acc();
    read_lit("t5_after_miss", 16'hFF81, 8'h3C);
    start(1'b1, 1'b0, 16'hFF10, 8'h00);
    tick(1);
    chk("t5_miss2_hit", hit, 1'b0);
    chk("t5_miss2_dout", data_out, 8'hFF);
    finish_acc();
    start(1'b1, 1'b1, 16'hFF80, 8'h99);
    tick(1);
    start(1'b0, 1'b1, 16'hFF82, 8'h4D);
    tick(1);
    finish_acc();
    read_lit("t5_rdwr_nowrite", 16'hFF80, 8'h5A);
    read_lit("t5_after_rdwr", 16'hFF82, 8'h4D);
    read_lit("t5_top_byte", 16'hFFFE, 8'h11);

    // Randomized traffic with background interrupt pulses
    rnd_irq = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic [15:0] a;
      int          sel, op;
      sel = $urandom_range(9);
      case (sel)
        5:       a = 16'hFF0F;
        6:       a = 16'hFFFF;
        7:       a = 16'hFFFE;
        8:       case ($urandom_range(3))
                   0: a = 16'hFF7F;
                   1: a = 16'hFF10;
                   2: a = 16'hFF0E;
                   default: a = 16'($urandom_range(16'hFF00));
                 endcase
        9:       a = 16'hFF80;
        default: a = 16'hFF80 + 16'($urandom_range(126));
      endcase
      op = $urandom_range(7);
      access(op < 4 || op == 7, op >= 4, a, 8'($urandom), 1 + $urandom_range(2));
    end
    rnd_irq = 1'b0;
    tick(0);
    tick(0);

    // Reset arriving before a write's edge drops that write
    access(1'b0, 1'b1, 16'hFF90, 8'h33, 1);
    start(1'b0, 1'b1, 16'hFF90, 8'h44);
    #2;
    apply_reset();
    while (m_clear > 0) tick(0);
`ifndef HRAM_CLEAR_EN
    read_lit("rst_drops_wr", 16'hFF90, 8'h33);
`endif
    read_lit("rst_if2", 16'hFF0F, 8'hE0);
    access(1'b1, 1'b0, 16'hFF90, 8'h00, 1);

`ifdef HRAM_CLEAR_EN
    // Sweep restarts when reset re-asserts part way through
    apply_reset();
    read_lit("sweep2_rd_ff", 16'hFFA0, 8'hFF);
    for (int i = 0; i < 46; i++) tick(0);
    chk("sweep_mid_ready", ready, 1'b0);
    apply_reset();
    while (m_clear > 0) tick(0);
    chk("sweep_done_ready", ready, 1'b1);
    for (int i = 0; i < 127; i++) read_lit("sweep_zero", 16'hFF80 + 16'(i), 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
